// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR addresses,
// exception codes, mstatus bit positions and the sequencing FSM states.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam logic [5:0] EXC_EBREAK  = 6'd3;
  localparam logic [5:0] EXC_ECALL_M = 6'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RETURN,
    REDIRECT
  } trap_state_t;

endpackage

// File: rtl/trap_unit_if.sv
// Pipeline-facing bundle of the trap unit: exception/MRET requests,
// CSR access port and the fetch redirect handshake.
interface trap_unit_if #(
  parameter int XLEN = 32
);
  logic            exception_valid_in;
  logic [5:0]      exception_num_in;
  logic [XLEN-1:0] exception_pc_in;
  logic [XLEN-1:0] exception_tval_in;
  logic            exception_ready;
  logic            mret_valid;
  logic [11:0]     csr_addr;
  logic            csr_wr_en;
  logic [XLEN-1:0] csr_wr_data;
  logic [XLEN-1:0] csr_rd_data;
  logic            csr_hit;
  logic            flush;
  logic            busy;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  // Pipeline side (execute stage + fetch).
  modport master (
    output exception_valid_in, exception_num_in, exception_pc_in, exception_tval_in,
    output mret_valid, csr_addr, csr_wr_en, csr_wr_data, redirect_ready,
    input  exception_ready, csr_rd_data, csr_hit, flush, busy,
    input  redirect_valid, redirect_pc
  );

  // Trap unit side.
  modport slave (
    input  exception_valid_in, exception_num_in, exception_pc_in, exception_tval_in,
    input  mret_valid, csr_addr, csr_wr_en, csr_wr_data, redirect_ready,
    output exception_ready, csr_rd_data, csr_hit, flush, busy,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/trap_csr_file.sv
// Trap CSR storage (mstatus MIE/MPIE, mtvec, mscratch, mepc, mcause, mtval)
// with write masking and a combinational read mux.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     csr_addr,
  input  logic            csr_wr_en,
  input  logic [XLEN-1:0] csr_wr_data,
  input  logic            save_en,
  input  logic [5:0]      save_num,
  input  logic [XLEN-1:0] save_pc,
  input  logic [XLEN-1:0] save_tval,
  input  logic            mret_en,
  output logic [XLEN-1:0] csr_rd_data,
  output logic            csr_hit,
  output logic [XLEN-1:0] mtvec_q,
  output logic [XLEN-1:0] mepc_q
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            mie_q;
  logic            mpie_q;
  logic [XLEN-1:0] mscratch_q;
  logic [5:0]      mcause_q;
  logic [XLEN-1:0] mtval_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= RESET_MTVEC & ALIGN_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (save_en) begin
      mepc_q   <= save_pc & ALIGN_MASK;
      mcause_q <= save_num;
      mtval_q  <= save_tval;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (mret_en) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (csr_wr_en) begin
      unique case (csr_addr)
        CSR_MSTATUS: begin
          mie_q  <= csr_wr_data[MSTATUS_MIE_BIT];
          mpie_q <= csr_wr_data[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:    mtvec_q    <= csr_wr_data & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_q <= csr_wr_data;
        CSR_MEPC:     mepc_q     <= csr_wr_data & ALIGN_MASK;
        CSR_MCAUSE:   mcause_q   <= csr_wr_data[5:0];
        CSR_MTVAL:    mtval_q    <= csr_wr_data;
        default: ;
      endcase
    end
  end

  // NOTE: both outputs get a default first so no path through the case
  // leaves them unassigned (which would infer a latch).
  always_comb begin
    csr_rd_data = '0;
    csr_hit     = 1'b1;
    unique case (csr_addr)
      CSR_MSTATUS: begin
        csr_rd_data[MSTATUS_MIE_BIT]  = mie_q;
        csr_rd_data[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MTVEC:    csr_rd_data = mtvec_q;
      CSR_MSCRATCH: csr_rd_data = mscratch_q;
      CSR_MEPC:     csr_rd_data = mepc_q;
      CSR_MCAUSE:   csr_rd_data = {{(XLEN-6){1'b0}}, mcause_q};
      CSR_MTVAL:    csr_rd_data = mtval_q;
      default:      csr_hit     = 1'b0;
    endcase
  end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap responder: sequences trap entry and MRET, then offers a
// PC redirect to fetch while flushing and stalling the pipeline.
module trap_unit
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic      clk,
  input  logic      reset,
  trap_unit_if.slave bus
);

  trap_state_t     state_q, state_d;
  logic [5:0]      hold_num;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] hold_tval;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;

  logic is_idle;
  logic take_exc;
  logic take_mret;
  logic csr_wr_ok;
  logic save_en;

  // Priority in IDLE: exception, then MRET, then CSR write.
  assign is_idle   = (state_q == IDLE);
  assign take_exc  = is_idle && bus.exception_valid_in;
  assign take_mret = is_idle && !bus.exception_valid_in && bus.mret_valid;
  assign csr_wr_ok = is_idle && !bus.exception_valid_in && !bus.mret_valid && bus.csr_wr_en;
  assign save_en   = (state_q == SAVE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_exc)       state_d = SAVE;
        else if (take_mret) state_d = RETURN;
      end
      SAVE:     state_d = REDIRECT;
      RETURN:   state_d = REDIRECT;
      REDIRECT: if (bus.redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.exception_ready = is_idle;
    bus.busy            = !is_idle;
    bus.flush           = !is_idle;
    bus.redirect_valid  = (state_q == REDIRECT);
    bus.redirect_pc     = target;
  end

  // Target only changes outside REDIRECT, so redirect_pc holds under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_num  <= '0;
      hold_pc   <= '0;
      hold_tval <= '0;
      target    <= '0;
    end else begin
      if (take_exc) begin
        hold_num  <= bus.exception_num_in;
        hold_pc   <= bus.exception_pc_in;
        hold_tval <= bus.exception_tval_in;
      end
      if (take_mret)    target <= mepc_q;
      else if (save_en) target <= mtvec_q;
    end
  end

  trap_csr_file #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr_file (
    .clk         (clk),
    .reset       (reset),
    .csr_addr    (bus.csr_addr),
    .csr_wr_en   (csr_wr_ok),
    .csr_wr_data (bus.csr_wr_data),
    .save_en     (save_en),
    .save_num    (hold_num),
    .save_pc     (hold_pc),
    .save_tval   (hold_tval),
    .mret_en     (take_mret),
    .csr_rd_data (bus.csr_rd_data),
    .csr_hit     (bus.csr_hit),
    .mtvec_q     (mtvec_q),
    .mepc_q      (mepc_q)
  );

endmodule
